// File: rtl/wb_reg_file.sv
// wb_reg_file: 32 x 32-bit write-back register file with two combinational
// read ports, a write-back source mux exported for EX-stage forwarding, and a
// saturating count of committed register writes.
// Optional build macro: WB_REG_FILE_BYPASS_EN -- when defined, a read port that
// addresses the register being committed this cycle returns the write-back
// value in the same cycle; when undefined, reads return stored contents only.
module wb_reg_file #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             WB_RegWrite_i,
    input  logic             WB_MemtoReg_i,
    input  logic [31:0]      DM_i,
    input  logic [31:0]      ALU_result_i,
    input  logic [4:0]       MUX2_i,
    input  logic [4:0]       RSaddr_i,
    input  logic [4:0]       RTaddr_i,
    output logic [31:0]      RSdata_o,
    output logic [31:0]      RTdata_o,
    output logic [31:0]      WB_data_o,
    output logic [CNT_W-1:0] wb_count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      regs_r [0:31];
    logic [CNT_W-1:0] count_r;
    logic [31:0]      wb_data_s;
    logic             commit_s;
    logic [31:0]      rs_data_s;
    logic [31:0]      rt_data_s;

    // Select the write-back value: memory load data or ALU result.
    always_comb begin
        wb_data_s = 32'd0;
        if (WB_MemtoReg_i) begin
            wb_data_s = DM_i;
        end else begin
            wb_data_s = ALU_result_i;
        end
    end

    // A write to register 0 is discarded and is not counted as a commit.
    always_comb begin
        commit_s = 1'b0;
        if (WB_RegWrite_i && (MUX2_i != 5'd0)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Register storage; reset clears every entry, commits update one entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (commit_s) begin
            regs_r[MUX2_i] <= wb_data_s;
        end
    end

    // Commit counter that holds at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= {CNT_W{1'b0}};
        end else if (commit_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    // Read port A: zero during reset and for index 0, optional same-cycle bypass.
    always_comb begin
        rs_data_s = 32'd0;
        if (rst_i) begin
            rs_data_s = 32'd0;
        end else if (RSaddr_i == 5'd0) begin
            rs_data_s = 32'd0;
`ifdef WB_REG_FILE_BYPASS_EN
        end else if (commit_s && (RSaddr_i == MUX2_i)) begin
            rs_data_s = wb_data_s;
`endif
        end else begin
            rs_data_s = regs_r[RSaddr_i];
        end
    end

    // Read port B: same rules as port A, fully independent of it.
    always_comb begin
        rt_data_s = 32'd0;
        if (rst_i) begin
            rt_data_s = 32'd0;
        end else if (RTaddr_i == 5'd0) begin
            rt_data_s = 32'd0;
`ifdef WB_REG_FILE_BYPASS_EN
        end else if (commit_s && (RTaddr_i == MUX2_i)) begin
            rt_data_s = wb_data_s;
`endif
        end else begin
            rt_data_s = regs_r[RTaddr_i];
        end
    end

    assign RSdata_o   = rs_data_s;
    assign RTdata_o   = rt_data_s;
    assign WB_data_o  = wb_data_s;
    assign wb_count_o = count_r;

endmodule

// File: doc/wb_reg_file.md
WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 Parameter: CNT_W, default 16, width of the commit counter.
REQ-002 Clock is clk_i; reset is rst_i, asynchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 WB_RegWrite_i  input  1  write-back enable from MEM/WB stage.
REQ-006 WB_MemtoReg_i  input  1  1 = write data memory value, 0 = write ALU result.
REQ-007 DM_i  input  32  data-memory read value.
REQ-008 ALU_result_i  input  32  ALU result.
REQ-009 MUX2_i  input  5  destination register index.
REQ-010 RSaddr_i  input  5  read port A index.
REQ-011 RTaddr_i  input  5  read port B index.
REQ-012 RSdata_o  output  32  read port A data.
REQ-013 RTdata_o  output  32  read port B data.
REQ-014 WB_data_o  output  32  selected write-back value, for EX-stage forwarding.
REQ-015 wb_count_o  output  CNT_W  count of committed register writes.

Function
REQ-016 WB_data_o SHALL equal DM_i when WB_MemtoReg_i=1, else ALU_result_i; combinational, zero latency.
REQ-017 Storage SHALL be 32 registers x 32 bits; register 0 SHALL always read 0.
REQ-018 A commit SHALL occur on a rising clk_i edge when rst_i=0, WB_RegWrite_i=1 and MUX2_i!=0; reg[MUX2_i] <= WB_data_o.
REQ-019 WB_RegWrite_i=1 with MUX2_i=0 SHALL write nothing and SHALL NOT count as a commit.
REQ-020 Read ports SHALL be combinational and independent; both ports may address the same register.
REQ-021 wb_count_o SHALL increment by 1 on each commit and SHALL saturate at all-ones (no wrap).
REQ-022 Commit and read of the same index in one cycle SHALL follow REQ-030/REQ-031.
REQ-023 Write enable with X/unknown control is out of scope; no other inputs affect state.

Reset
REQ-024 While rst_i=1, all 32 registers SHALL be 0 and wb_count_o SHALL be 0, asynchronously.
REQ-025 While rst_i=1, RSdata_o and RTdata_o SHALL read 0 for any index, including bypass cases.
REQ-026 A commit presented in a cycle with rst_i=1 SHALL be dropped, not applied after reset release.
REQ-027 The first commit SHALL occur on the first rising edge with rst_i=0.
REQ-028 WB_data_o SHALL remain the REQ-016 mux during reset (pure combinational).

Configuration
REQ-029 Macro WB_REG_FILE_BYPASS_EN selects same-cycle write-to-read bypass.
REQ-030 With WB_REG_FILE_BYPASS_EN defined: when WB_RegWrite_i=1, MUX2_i!=0, rst_i=0 and a read index equals MUX2_i, that port SHALL output WB_data_o in the same cycle.
REQ-031 Without WB_REG_FILE_BYPASS_EN: read ports SHALL output stored contents only; new value visible the cycle after the commit edge.

Verification
REQ-032 Reset then read all 32 indices on both ports -> all 0, wb_count_o=0.
REQ-033 RegWrite=1, MemtoReg=0, ALU=0x0000_00AB, MUX2=5, one edge; RSaddr=5 -> RSdata_o=0x0000_00AB, wb_count_o=1.
REQ-034 RegWrite=1, MemtoReg=1, DM=0xDEAD_BEEF, ALU=0x1, MUX2=0 -> reg0 reads 0, wb_count_o unchanged, WB_data_o=0xDEAD_BEEF.
REQ-035 reg7=0x11, commit 0x22 to 7 with RSaddr=RTaddr=7 in the commit cycle -> both ports 0x22 pre-edge with BYPASS_EN, 0x11 pre-edge without; 0x22 post-edge in both builds.
REQ-036 CNT_W=4, 20 commits to index 3 -> wb_count_o stops at 0xF; then assert rst_i mid-cycle -> count 0 and reg3 0 immediately, that cycle's commit dropped.
